// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, ALU func codes,
// branch codes, the default start PC and a saturating-increment helper.
`timescale 1ns/1ps
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6
    } seq_state_e;

    // OP=0 func codes (IR[7:4])
    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_MOV  = 4'b0001;
    localparam logic [3:0] FN_HALT = 4'b0010;
    localparam logic [3:0] FN_SUB  = 4'b0011;
    localparam logic [3:0] FN_AND  = 4'b0100;
    localparam logic [3:0] FN_OR   = 4'b0101;
    localparam logic [3:0] FN_SLL  = 4'b0110;
    localparam logic [3:0] FN_SRL  = 4'b0111;
    localparam logic [3:0] FN_XOR  = 4'b1000;
    localparam logic [3:0] FN_NOT  = 4'b1001;
    localparam logic [3:0] FN_BEZR = 4'b1010;
    localparam logic [3:0] FN_SW   = 4'b1011;
    localparam logic [3:0] FN_LW   = 4'b1100;

    // OP=1 func codes (IR[7:6])
    localparam logic [1:0] FI_SETI = 2'b00;
    localparam logic [1:0] FI_SLIZ = 2'b01;
    localparam logic [1:0] FI_SLTI = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_FWD  = 2'b01;
    localparam logic [1:0] BR_BWD  = 2'b10;

    localparam int SEQ_START_PC = 0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer (master) and the CPU datapath / instruction memory (slave).
// Counter signals exist only when SEQ_PERF_COUNT_EN is defined.
`timescale 1ns/1ps
interface alu_sequencer_if #(parameter int PC_W = 8);
    logic            Start;
    logic [8:0]      Instr;
    logic [7:0]      AluOut;
    logic [1:0]      AluZero;
    logic            AluCarry;
    logic [PC_W-1:0] PC;
    logic            InstrRd;
    logic            AluOp;
    logic [3:0]      AluFunc;
    logic [3:0]      RegAddr;
    logic [7:0]      Imm;
    logic            ImmSel;
    logic            AccWe;
    logic            RegWe;
    logic            MemRe;
    logic            MemWe;
    logic            CarryFlag;
    logic            Done;
`ifdef SEQ_PERF_COUNT_EN
    logic [15:0]     CycleCnt;
    logic [15:0]     InstrCnt;
`endif

    modport master (
        input  Start, Instr, AluOut, AluZero, AluCarry,
        output PC, InstrRd, AluOp, AluFunc, RegAddr, Imm, ImmSel,
        output AccWe, RegWe, MemRe, MemWe, CarryFlag, Done
`ifdef SEQ_PERF_COUNT_EN
        , output CycleCnt, InstrCnt
`endif
    );

    modport slave (
        output Start, Instr, AluOut, AluZero, AluCarry,
        input  PC, InstrRd, AluOp, AluFunc, RegAddr, Imm, ImmSel,
        input  AccWe, RegWe, MemRe, MemWe, CarryFlag, Done
`ifdef SEQ_PERF_COUNT_EN
        , input CycleCnt, InstrCnt
`endif
    );
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: IR[8:4] -> ALU controls and per-instruction class flags.
`timescale 1ns/1ps
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [8:4] ir_hi,
    output logic       alu_op,
    output logic [3:0] alu_func,
    output logic       imm_sel,
    output logic       wr_acc,
    output logic       wr_reg,
    output logic       is_mem_rd,
    output logic       is_mem_wr,
    output logic       is_halt,
    output logic       is_branch,
    output logic       is_carry
);

    // Illegal codes fall through to the defaults and behave as a NOP
    always_comb begin
        alu_op    = ir_hi[8];
        imm_sel   = ir_hi[8];
        alu_func  = 4'd0;
        wr_acc    = 1'b0;
        wr_reg    = 1'b0;
        is_mem_rd = 1'b0;
        is_mem_wr = 1'b0;
        is_halt   = 1'b0;
        is_branch = 1'b0;
        is_carry  = 1'b0;
        if (ir_hi[8]) begin
            alu_func = {2'b00, ir_hi[7:6]};
            case (ir_hi[7:6])
                FI_SETI, FI_SLIZ, FI_SLTI: wr_acc = 1'b1;
                default:                   wr_acc = 1'b0;
            endcase
        end else begin
            alu_func = ir_hi[7:4];
            case (ir_hi[7:4])
                FN_ADD, FN_SLL: begin
                    wr_acc   = 1'b1;
                    is_carry = 1'b1;
                end
                FN_MOV:  wr_reg = 1'b1;
                FN_HALT: is_halt = 1'b1;
                FN_SUB, FN_AND, FN_OR, FN_SRL, FN_XOR, FN_NOT: wr_acc = 1'b1;
                FN_BEZR: is_branch = 1'b1;
                FN_SW:   is_mem_wr = 1'b1;
                FN_LW: begin
                    is_mem_rd = 1'b1;
                    wr_acc    = 1'b1;
                end
                default: wr_acc = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb controller owning PC, IR and the carry flag.
// Optional cycle/instruction counters are built when SEQ_PERF_COUNT_EN is defined.
`timescale 1ns/1ps
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int START_PC = SEQ_START_PC
)(
    input  logic           CLK,
    input  logic           Reset,
    alu_sequencer_if.master bus
);

    localparam logic [PC_W-1:0] PC_INIT = PC_W'(START_PC);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1'b1);

    seq_state_e      state_r;
    logic [PC_W-1:0] pc_r;
    logic [8:0]      ir_r;
    logic            carry_r;
    logic [PC_W-1:0] pc_next_s;
    logic            exec_s;
    logic            wb_s;
    logic            ctrl_s;

    logic       dec_alu_op_s;
    logic [3:0] dec_alu_func_s;
    logic       dec_imm_sel_s;
    logic       dec_wr_acc_s;
    logic       dec_wr_reg_s;
    logic       dec_mem_rd_s;
    logic       dec_mem_wr_s;
    logic       dec_halt_s;
    logic       dec_branch_s;
    logic       dec_carry_s;

    alu_seq_decode u_decode (
        .ir_hi     (ir_r[8:4]),
        .alu_op    (dec_alu_op_s),
        .alu_func  (dec_alu_func_s),
        .imm_sel   (dec_imm_sel_s),
        .wr_acc    (dec_wr_acc_s),
        .wr_reg    (dec_wr_reg_s),
        .is_mem_rd (dec_mem_rd_s),
        .is_mem_wr (dec_mem_wr_s),
        .is_halt   (dec_halt_s),
        .is_branch (dec_branch_s),
        .is_carry  (dec_carry_s)
    );

    // Next PC taken at WB exit; AluZero=11 is treated like "not taken"
    always_comb begin
        pc_next_s = pc_r + PC_ONE;
        if (dec_branch_s) begin
            case (bus.AluZero)
                BR_FWD:  pc_next_s = pc_r + PC_W'(bus.AluOut);
                BR_BWD:  pc_next_s = pc_r - PC_W'(bus.AluOut);
                BR_NONE: pc_next_s = pc_r + PC_ONE;
                default: pc_next_s = pc_r + PC_ONE;
            endcase
        end else begin
            pc_next_s = pc_r + PC_ONE;
        end
    end

    // Sequencer state, PC, IR and carry flag
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
            pc_r    <= PC_INIT;
            ir_r    <= 9'd0;
            carry_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALTED: begin
                    if (bus.Start) begin
                        state_r <= ST_FETCH;
                        pc_r    <= PC_INIT;
                        carry_r <= 1'b0;
                    end
                end
                ST_FETCH: state_r <= ST_DECODE;
                ST_DECODE: begin
                    ir_r    <= bus.Instr;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec_halt_s)        state_r <= ST_HALTED;
                    else if (dec_mem_rd_s) state_r <= ST_MEM;
                    else                   state_r <= ST_WB;
                end
                ST_MEM: state_r <= ST_WB;
                ST_WB: begin
                    if (dec_carry_s) carry_r <= bus.AluCarry;
                    pc_r    <= pc_next_s;
                    state_r <= ST_FETCH;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign exec_s = (state_r == ST_EXEC);
    assign wb_s   = (state_r == ST_WB);
    assign ctrl_s = exec_s || wb_s || (state_r == ST_MEM);

    assign bus.PC        = pc_r;
    assign bus.InstrRd   = (state_r == ST_FETCH);
    assign bus.Done      = (state_r == ST_HALTED);
    assign bus.CarryFlag = carry_r;
    assign bus.AluOp     = ctrl_s & dec_alu_op_s;
    assign bus.AluFunc   = ctrl_s ? dec_alu_func_s : 4'd0;
    assign bus.RegAddr   = ctrl_s ? ir_r[3:0] : 4'd0;
    assign bus.Imm       = ctrl_s ? {2'b00, ir_r[5:0]} : 8'd0;
    assign bus.ImmSel    = ctrl_s & dec_imm_sel_s;
    assign bus.MemRe     = exec_s & dec_mem_rd_s;
    assign bus.MemWe     = exec_s & dec_mem_wr_s;
    assign bus.AccWe     = wb_s & dec_wr_acc_s;
    assign bus.RegWe     = wb_s & dec_wr_reg_s;

`ifdef SEQ_PERF_COUNT_EN
    logic [15:0] cycle_cnt_r;
    logic [15:0] instr_cnt_r;

    // Saturating run counters, cleared whenever a new run starts
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cycle_cnt_r <= 16'd0;
            instr_cnt_r <= 16'd0;
        end else if (state_r == ST_IDLE || state_r == ST_HALTED) begin
            if (bus.Start) begin
                cycle_cnt_r <= 16'd0;
                instr_cnt_r <= 16'd0;
            end
        end else begin
            cycle_cnt_r <= sat_inc16(cycle_cnt_r);
            if (exec_s) instr_cnt_r <= sat_inc16(instr_cnt_r);
        end
    end

    assign bus.CycleCnt = cycle_cnt_r;
    assign bus.InstrCnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven bench for alu_sequencer: a program of directed instructions with
// hand-computed controls, latency, PC and carry, plus halt/restart/reset sequences.
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_sequencer_if #(.PC_W(8)) bus ();

    alu_sequencer #(.PC_W(8), .START_PC(0)) dut (
        .CLK   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] instr;
        logic [1:0] zero;
        logic [7:0] alu_out;
        logic       carry_in;
        int         lat;
        logic       op;
        logic [3:0] func;
        logic [3:0] reg_addr;
        logic [7:0] imm;
        logic       imm_sel;
        int         acc_n;
        int         reg_n;
        int         mre_n;
        int         mwe_n;
        logic [7:0] pc_after;
        logic       carry_after;
        logic       done_after;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Entered at a FETCH-cycle negedge; leaves at the next FETCH or HALTED negedge.
    task automatic exec_one(input vec_t v, input int idx);
        int n;
        int acc_n, reg_n, mre_n, mwe_n;
        logic e_op, e_sel, e_mre, e_mwe;
        logic [3:0] e_func, e_reg;
        logic [7:0] e_imm;
        n = 0; acc_n = 0; reg_n = 0; mre_n = 0; mwe_n = 0;
        e_op = 1'b0; e_sel = 1'b0; e_mre = 1'b0; e_mwe = 1'b0;
        e_func = 4'd0; e_reg = 4'd0; e_imm = 8'd0;
        bus.Instr    = v.instr;
        bus.AluZero  = v.zero;
        bus.AluOut   = v.alu_out;
        bus.AluCarry = v.carry_in;
        chk($sformatf("v%0d_instr_rd", idx), {31'd0, bus.InstrRd}, 32'd1);
        do begin
            if (n == 2) begin
                e_op = bus.AluOp; e_func = bus.AluFunc; e_reg = bus.RegAddr;
                e_imm = bus.Imm; e_sel = bus.ImmSel; e_mre = bus.MemRe; e_mwe = bus.MemWe;
            end
            acc_n += int'(bus.AccWe);
            reg_n += int'(bus.RegWe);
            mre_n += int'(bus.MemRe);
            mwe_n += int'(bus.MemWe);
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!bus.InstrRd && !bus.Done && n < 8);
        chk($sformatf("v%0d_latency", idx), n, v.lat);
        chk($sformatf("v%0d_alu_op", idx), {31'd0, e_op}, {31'd0, v.op});
        chk($sformatf("v%0d_alu_func", idx), {28'd0, e_func}, {28'd0, v.func});
        chk($sformatf("v%0d_reg_addr", idx), {28'd0, e_reg}, {28'd0, v.reg_addr});
        chk($sformatf("v%0d_imm", idx), {24'd0, e_imm}, {24'd0, v.imm});
        chk($sformatf("v%0d_imm_sel", idx), {31'd0, e_sel}, {31'd0, v.imm_sel});
        chk($sformatf("v%0d_mem_re_exec", idx), {31'd0, e_mre}, (v.mre_n > 0) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d_mem_we_exec", idx), {31'd0, e_mwe}, (v.mwe_n > 0) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d_acc_we_cnt", idx), acc_n, v.acc_n);
        chk($sformatf("v%0d_reg_we_cnt", idx), reg_n, v.reg_n);
        chk($sformatf("v%0d_mem_re_cnt", idx), mre_n, v.mre_n);
        chk($sformatf("v%0d_mem_we_cnt", idx), mwe_n, v.mwe_n);
        chk($sformatf("v%0d_pc", idx), {24'd0, bus.PC}, {24'd0, v.pc_after});
        chk($sformatf("v%0d_carry", idx), {31'd0, bus.CarryFlag}, {31'd0, v.carry_after});
        chk($sformatf("v%0d_done", idx), {31'd0, bus.Done}, {31'd0, v.done_after});
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_ctrl"}, {19'd0, bus.InstrRd, bus.AluOp, bus.AluFunc, bus.ImmSel,
                              bus.AccWe, bus.RegWe, bus.MemRe, bus.MemWe, bus.Done, bus.CarryFlag},
            32'd0);
        chk({name, "_fields"}, {24'd0, bus.RegAddr, bus.Imm[3:0]}, 32'd0);
        chk({name, "_pc"}, {24'd0, bus.PC}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int exp_cycles;
        checks = 0; failures = 0; exp_cycles = 0;
        //            instr           zero   out    cin   lat op func   reg    imm     sel acc reg mre mwe pc      cf    done
        vecs[0]  = '{9'b0_0000_0011, 2'b00, 8'd0,  1'b1, 4, 1'b0, 4'h0, 4'd3, 8'h03, 1'b0, 1, 0, 0, 0, 8'd1,   1'b1, 1'b0};
        vecs[1]  = '{9'b1_01_000010, 2'b00, 8'd0,  1'b0, 4, 1'b1, 4'h1, 4'd2, 8'h02, 1'b1, 1, 0, 0, 0, 8'd2,   1'b1, 1'b0};
        vecs[2]  = '{9'b0_0001_0101, 2'b00, 8'd0,  1'b0, 4, 1'b0, 4'h1, 4'd5, 8'h15, 1'b0, 0, 1, 0, 0, 8'd3,   1'b1, 1'b0};
        vecs[3]  = '{9'b0_0110_0001, 2'b00, 8'd0,  1'b0, 4, 1'b0, 4'h6, 4'd1, 8'h21, 1'b0, 1, 0, 0, 0, 8'd4,   1'b0, 1'b0};
        vecs[4]  = '{9'b0_1100_0100, 2'b00, 8'd0,  1'b1, 5, 1'b0, 4'hC, 4'd4, 8'h04, 1'b0, 1, 0, 1, 0, 8'd5,   1'b0, 1'b0};
        vecs[5]  = '{9'b0_1011_0110, 2'b00, 8'd0,  1'b0, 4, 1'b0, 4'hB, 4'd6, 8'h36, 1'b0, 0, 0, 0, 1, 8'd6,   1'b0, 1'b0};
        vecs[6]  = '{9'b0_1101_0000, 2'b00, 8'd0,  1'b1, 4, 1'b0, 4'hD, 4'd0, 8'h10, 1'b0, 0, 0, 0, 0, 8'd7,   1'b0, 1'b0};
        vecs[7]  = '{9'b1_11_000111, 2'b00, 8'd0,  1'b1, 4, 1'b1, 4'h3, 4'd7, 8'h07, 1'b1, 0, 0, 0, 0, 8'd8,   1'b0, 1'b0};
        vecs[8]  = '{9'b0_1010_0000, 2'b11, 8'd4,  1'b0, 4, 1'b0, 4'hA, 4'd0, 8'h20, 1'b0, 0, 0, 0, 0, 8'd9,   1'b0, 1'b0};
        vecs[9]  = '{9'b0_0000_0001, 2'b00, 8'd0,  1'b1, 4, 1'b0, 4'h0, 4'd1, 8'h01, 1'b0, 1, 0, 0, 0, 8'd10,  1'b1, 1'b0};
        vecs[10] = '{9'b0_1010_0000, 2'b01, 8'd5,  1'b0, 4, 1'b0, 4'hA, 4'd0, 8'h20, 1'b0, 0, 0, 0, 0, 8'd15,  1'b1, 1'b0};
        vecs[11] = '{9'b0_1010_0000, 2'b10, 8'd8,  1'b0, 4, 1'b0, 4'hA, 4'd0, 8'h20, 1'b0, 0, 0, 0, 0, 8'd7,   1'b1, 1'b0};
        vecs[12] = '{9'b0_1010_0000, 2'b00, 8'd9,  1'b0, 4, 1'b0, 4'hA, 4'd0, 8'h20, 1'b0, 0, 0, 0, 0, 8'd8,   1'b1, 1'b0};
        vecs[13] = '{9'b0_1010_0000, 2'b10, 8'd9,  1'b0, 4, 1'b0, 4'hA, 4'd0, 8'h20, 1'b0, 0, 0, 0, 0, 8'd255, 1'b1, 1'b0};
        vecs[14] = '{9'b0_1010_0000, 2'b01, 8'd2,  1'b0, 4, 1'b0, 4'hA, 4'd0, 8'h20, 1'b0, 0, 0, 0, 0, 8'd1,   1'b1, 1'b0};
        vecs[15] = '{9'b0_0010_0000, 2'b00, 8'd0,  1'b1, 3, 1'b0, 4'h2, 4'd0, 8'h20, 1'b0, 0, 0, 0, 0, 8'd1,   1'b1, 1'b1};

        rst_n = 1'b0;
        bus.Start = 1'b0; bus.Instr = 9'd0; bus.AluOut = 8'd0; bus.AluZero = 2'b00; bus.AluCarry = 1'b0;
        #13;
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", {31'd0, bus.InstrRd}, 32'd0);

        bus.Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b0;
        chk("start_pc", {24'd0, bus.PC}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            exec_one(vecs[i], i);
            exp_cycles += vecs[i].lat;
        end
`ifdef SEQ_PERF_COUNT_EN
        chk("instr_cnt", {16'd0, bus.InstrCnt}, 32'd16);
        chk("cycle_cnt", {16'd0, bus.CycleCnt}, exp_cycles);
`endif

        // Halted: PC and Done frozen
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("halt_hold_%0d", i), {23'd0, bus.Done, bus.PC}, {23'd0, 1'b1, 8'd1});
        end

        bus.Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart_pc", {24'd0, bus.PC}, 32'd0);
        chk("restart_done", {31'd0, bus.Done}, 32'd0);
        chk("restart_carry", {31'd0, bus.CarryFlag}, 32'd0);
`ifdef SEQ_PERF_COUNT_EN
        chk("restart_instr_cnt", {16'd0, bus.InstrCnt}, 32'd0);
`endif

        // Start held high through a run is ignored
        v = '{9'b0_0000_0010, 2'b00, 8'd0, 1'b1, 4, 1'b0, 4'h0, 4'd2, 8'h02, 1'b0, 1, 0, 0, 0, 8'd1, 1'b1, 1'b0};
        exec_one(v, 100);
        bus.Start = 1'b0;

        // Async reset in the middle of EXEC of an add
        bus.Instr = 9'b0_0000_0111;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_reset_func_reg", {28'd0, bus.RegAddr}, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_exec_reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b0;
        chk("post_reset_fetch", {31'd0, bus.InstrRd}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
